// File: rtl/bit_serializer.sv
// Word-to-bit serializer: a small FIFO of WIDTH-bit words shifted out MSB-first, paced by shift_en_i.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           word_in_i,
  input  logic                       word_valid_i,
  output logic                       word_ready_o,
  input  logic                       shift_en_i,
  output logic                       bit_out_o,
  output logic                       bit_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             push, pop, word_end;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign word_ready_o = (count_q < CW'(DEPTH));
  assign push         = word_valid_i & word_ready_o;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    pop         = 1'b0;
    word_end    = 1'b0;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          bit_cnt_d = BW'(WIDTH - 1);
`ifdef SER_PARITY_EN
          par_d     = ^mem_q[rd_ptr_q];
`endif
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_en_i) begin
          bit_out_d   = shreg_q[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          bit_cnt_d   = bit_cnt_q - BW'(1);
          if (bit_cnt_q == '0) begin
`ifdef SER_PARITY_EN
            state_d = S_PARITY;
`else
            word_end = 1'b1;
`endif
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (shift_en_i) begin
          bit_out_d   = par_q;
          bit_valid_d = 1'b1;
          word_end    = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Reloading on the final slot keeps back-to-back words bubble-free.
    if (word_end) begin
      if (count_q != '0) begin
        pop       = 1'b1;
        shreg_d   = mem_q[rd_ptr_q];
        bit_cnt_d = BW'(WIDTH - 1);
`ifdef SER_PARITY_EN
        par_d     = ^mem_q[rd_ptr_q];
`endif
        state_d   = S_SHIFT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= word_in_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bit_out_o    = bit_out_q;
  assign bit_valid_o  = bit_valid_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
